// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types for the UART command assembler: FSM state enum and the
// encodings shown on the state_dbg LEDs.
package uart_cmd_pkg;

  localparam logic [3:0] STATE_DBG_OPERAND = 4'd0;
  localparam logic [3:0] STATE_DBG_CMD     = 4'd1;
  localparam logic [3:0] STATE_DBG_PRESENT = 4'd2;

  typedef enum logic [3:0] {
    S_OPERAND = STATE_DBG_OPERAND,
    S_CMD     = STATE_DBG_CMD,
    S_PRESENT = STATE_DBG_PRESENT
  } state_e;

endpackage

// File: rtl/uart_cmd_assembler_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags when the count sits at LIMIT-1.
module byte_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT);

  if (LIMIT < 2) begin : g_bad_limit
    $error("byte_timeout_counter: LIMIT must be at least 2");
  end

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over enable so an accepted byte always restarts the window
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/uart_cmd_assembler.sv
// Collects UART bytes into a frame of little-endian operands plus a command
// byte, presents the frame with a valid/ready handshake, and flags dropped
// bytes and stalled partial frames.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int N_OPERANDS    = 2,
  parameter int OPERAND_BYTES = 2,
  parameter int BYTE_TIMEOUT  = 1000000,
  parameter int DATA_W        = 8 * OPERAND_BYTES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                rx_ready,
  input  logic [7:0]                          rx_data,
  input  logic                                frame_ready,
  input  logic [$clog2(N_OPERANDS+1)-1:0]     data_sel,
  output logic                                frame_valid,
  output logic [N_OPERANDS*DATA_W-1:0]        operands,
  output logic [7:0]                          cmd,
  output logic [DATA_W-1:0]                   data_out,
  output logic                                timeout_err,
  output logic                                overrun_err,
  output logic [3:0]                          state_dbg
);

  localparam int SEL_W   = $clog2(N_OPERANDS + 1);
  localparam int OP_W    = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1;
  localparam int BYTE_W  = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam int N_SLOTS = N_OPERANDS * OPERAND_BYTES;
  localparam logic [OP_W-1:0]   LAST_OP   = OP_W'(N_OPERANDS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(OPERAND_BYTES - 1);

  if (N_OPERANDS < 1 || N_OPERANDS > 8) begin : g_bad_operands
    $error("uart_cmd_assembler: N_OPERANDS must be 1..8");
  end
  if (OPERAND_BYTES < 1 || OPERAND_BYTES > 4) begin : g_bad_bytes
    $error("uart_cmd_assembler: OPERAND_BYTES must be 1..4");
  end
  if (BYTE_TIMEOUT < 2) begin : g_bad_timeout
    $error("uart_cmd_assembler: BYTE_TIMEOUT must be at least 2");
  end

  state_e                       state_q, state_d;
  logic [OP_W-1:0]              op_idx_q, op_idx_d;
  logic [BYTE_W-1:0]            byte_idx_q, byte_idx_d;
  logic [N_OPERANDS*DATA_W-1:0] work_q, work_d;
  logic [N_OPERANDS*DATA_W-1:0] operands_q, operands_d;
  logic [7:0]                   cmd_q, cmd_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         timeout_err_q, timeout_err_d;
  logic                         overrun_err_q, overrun_err_d;

  logic started;
  logic tmo_enable;
  logic tmo_clear;
  logic tmo_expired;

  // The idle window only runs once a frame is under way; it restarts on every
  // strobe and after it fires so an abort leaves it at zero
  always_comb begin
    started    = (op_idx_q != '0) || (byte_idx_q != '0);
    tmo_enable = (state_q == S_CMD) || ((state_q == S_OPERAND) && started);
    tmo_clear  = rx_ready || !tmo_enable || tmo_expired;
  end

  byte_timeout_counter #(
    .LIMIT(BYTE_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // Next-state logic for frame collection, command capture and presentation
  always_comb begin
    state_d       = state_q;
    op_idx_d      = op_idx_q;
    byte_idx_d    = byte_idx_q;
    work_d        = work_q;
    operands_d    = operands_q;
    cmd_d         = cmd_q;
    frame_valid_d = frame_valid_q;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;

    case (state_q)
      S_OPERAND: begin
        if (rx_ready) begin
          for (int s = 0; s < N_SLOTS; s++) begin
            if (op_idx_q == OP_W'(s / OPERAND_BYTES) &&
                byte_idx_q == BYTE_W'(s % OPERAND_BYTES)) begin
              work_d[s*8 +: 8] = rx_data;
            end
          end
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            if (op_idx_q == LAST_OP) begin
              op_idx_d = '0;
              state_d  = S_CMD;
            end else begin
              op_idx_d = op_idx_q + OP_W'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
          end
        end
      end
      S_CMD: begin
        if (rx_ready) begin
          operands_d    = work_q;
          cmd_d         = rx_data;
          frame_valid_d = 1'b1;
          state_d       = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (rx_ready) begin
          overrun_err_d = 1'b1;
        end
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          op_idx_d      = '0;
          byte_idx_d    = '0;
          state_d       = S_OPERAND;
        end
      end
      default: begin
        state_d = S_OPERAND;
      end
    endcase

    if ((state_q == S_OPERAND || state_q == S_CMD) && tmo_expired && !rx_ready) begin
      state_d       = S_OPERAND;
      op_idx_d      = '0;
      byte_idx_d    = '0;
      timeout_err_d = 1'b1;
    end
  end

  // State and registered outputs; reset discards any partial or held frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_OPERAND;
      op_idx_q      <= '0;
      byte_idx_q    <= '0;
      work_q        <= '0;
      operands_q    <= '0;
      cmd_q         <= '0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_idx_q      <= op_idx_d;
      byte_idx_q    <= byte_idx_d;
      work_q        <= work_d;
      operands_q    <= operands_d;
      cmd_q         <= cmd_d;
      frame_valid_q <= frame_valid_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Readback mux; the command sits above the last operand, anything else
  // falls back to operand 0
  always_comb begin
    data_out = operands_q[DATA_W-1:0];
    for (int i = 0; i < N_OPERANDS; i++) begin
      if (data_sel == SEL_W'(i)) begin
        data_out = operands_q[i*DATA_W +: DATA_W];
      end
    end
    if (data_sel == SEL_W'(N_OPERANDS)) begin
      data_out = DATA_W'(cmd_q);
    end
  end

  assign frame_valid = frame_valid_q;
  assign operands    = operands_q;
  assign cmd         = cmd_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: a default-sized instance with a
// short timeout, a 3x1-byte instance and a minimal 1x1-byte instance.
module tb_uart_cmd_assembler;

  logic clk;
  logic reset;
  logic [7:0] rxData;

  logic rxReadyA, frameReadyA, frameValidA, timeoutErrA, overrunErrA;
  logic [1:0]  dataSelA;
  logic [31:0] operandsA;
  logic [7:0]  cmdA;
  logic [15:0] dataOutA;
  logic [3:0]  stateDbgA;

  logic rxReadyB, frameReadyB, frameValidB, timeoutErrB, overrunErrB;
  logic [1:0]  dataSelB;
  logic [23:0] operandsB;
  logic [7:0]  cmdB;
  logic [7:0]  dataOutB;
  logic [3:0]  stateDbgB;

  logic rxReadyC, frameReadyC, frameValidC, timeoutErrC, overrunErrC;
  logic [0:0]  dataSelC;
  logic [7:0]  operandsC;
  logic [7:0]  cmdC;
  logic [7:0]  dataOutC;
  logic [3:0]  stateDbgC;

  int checkCount = 0;
  int errorCount = 0;

  uart_cmd_assembler #(.N_OPERANDS(2), .OPERAND_BYTES(2), .BYTE_TIMEOUT(16)) dutA (
    .clk(clk), .reset(reset), .rx_ready(rxReadyA), .rx_data(rxData),
    .frame_ready(frameReadyA), .data_sel(dataSelA), .frame_valid(frameValidA),
    .operands(operandsA), .cmd(cmdA), .data_out(dataOutA),
    .timeout_err(timeoutErrA), .overrun_err(overrunErrA), .state_dbg(stateDbgA)
  );

  uart_cmd_assembler #(.N_OPERANDS(3), .OPERAND_BYTES(1)) dutB (
    .clk(clk), .reset(reset), .rx_ready(rxReadyB), .rx_data(rxData),
    .frame_ready(frameReadyB), .data_sel(dataSelB), .frame_valid(frameValidB),
    .operands(operandsB), .cmd(cmdB), .data_out(dataOutB),
    .timeout_err(timeoutErrB), .overrun_err(overrunErrB), .state_dbg(stateDbgB)
  );

  uart_cmd_assembler #(.N_OPERANDS(1), .OPERAND_BYTES(1), .BYTE_TIMEOUT(2)) dutC (
    .clk(clk), .reset(reset), .rx_ready(rxReadyC), .rx_data(rxData),
    .frame_ready(frameReadyC), .data_sel(dataSelC), .frame_valid(frameValidC),
    .operands(operandsC), .cmd(cmdC), .data_out(dataOutC),
    .timeout_err(timeoutErrC), .overrun_err(overrunErrC), .state_dbg(stateDbgC)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a failure with both values
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Strobes one byte into the chosen instance for a single clock edge
  task automatic applyStimulus(input int which, input logic [7:0] value);
    rxData = value;
    rxReadyA = (which == 0);
    rxReadyB = (which == 1);
    rxReadyC = (which == 2);
    @(posedge clk);
    #1;
    rxReadyA = 1'b0;
    rxReadyB = 1'b0;
    rxReadyC = 1'b0;
  endtask

  // Waits a number of clock edges, leaving time 1 ns past the last edge
  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Directed scenario sequence
  initial begin
    reset = 1'b0;
    rxData = 8'h00;
    rxReadyA = 1'b0; rxReadyB = 1'b0; rxReadyC = 1'b0;
    frameReadyA = 1'b0; frameReadyB = 1'b0; frameReadyC = 1'b0;
    dataSelA = 2'd0; dataSelB = 2'd0; dataSelC = 1'b0;
    idleCycles(2);

    checkOutput("rst_frame_valid", 64'(frameValidA), 64'h0);
    checkOutput("rst_operands", 64'(operandsA), 64'h0);
    checkOutput("rst_cmd", 64'(cmdA), 64'h0);
    checkOutput("rst_state", 64'(stateDbgA), 64'h0);
    checkOutput("rst_timeout", 64'(timeoutErrA), 64'h0);
    checkOutput("rst_overrun", 64'(overrunErrA), 64'h0);
    reset = 1'b1;
    idleCycles(1);

    // Basic frame
    applyStimulus(0, 8'h34);
    applyStimulus(0, 8'h12);
    applyStimulus(0, 8'h78);
    checkOutput("collect_state", 64'(stateDbgA), 64'h0);
    applyStimulus(0, 8'h56);
    checkOutput("cmd_wait_state", 64'(stateDbgA), 64'h1);
    checkOutput("cmd_wait_no_valid", 64'(frameValidA), 64'h0);
    applyStimulus(0, 8'h03);
    checkOutput("frame1_valid", 64'(frameValidA), 64'h1);
    checkOutput("frame1_operands", 64'(operandsA), 64'h5678_1234);
    checkOutput("frame1_cmd", 64'(cmdA), 64'h03);
    dataSelA = 2'd2; #1;
    checkOutput("frame1_sel_cmd", 64'(dataOutA), 64'h0003);
    dataSelA = 2'd1; #1;
    checkOutput("frame1_sel_op1", 64'(dataOutA), 64'h5678);
    dataSelA = 2'd3; #1;
    checkOutput("frame1_sel_oob", 64'(dataOutA), 64'h1234);
    dataSelA = 2'd0;

    // Backpressure then handshake
    for (int i = 0; i < 10; i++) begin
      idleCycles(1);
      checkOutput("hold_valid", 64'(frameValidA), 64'h1);
      checkOutput("hold_state", 64'(stateDbgA), 64'h2);
    end
    frameReadyA = 1'b1;
    idleCycles(1);
    frameReadyA = 1'b0;
    checkOutput("handshake_valid_clear", 64'(frameValidA), 64'h0);
    checkOutput("handshake_state", 64'(stateDbgA), 64'h0);
    checkOutput("handshake_operands_kept", 64'(operandsA), 64'h5678_1234);

    // Partial frame abandoned: 15 idle cycles are tolerated, the 16th aborts
    applyStimulus(0, 8'h34);
    applyStimulus(0, 8'h12);
    idleCycles(15);
    checkOutput("pre_timeout_quiet", 64'(timeoutErrA), 64'h0);
    idleCycles(1);
    checkOutput("timeout_pulse", 64'(timeoutErrA), 64'h1);
    checkOutput("timeout_state", 64'(stateDbgA), 64'h0);
    checkOutput("timeout_operands_kept", 64'(operandsA), 64'h5678_1234);
    checkOutput("timeout_cmd_kept", 64'(cmdA), 64'h03);
    idleCycles(1);
    checkOutput("timeout_single_pulse", 64'(timeoutErrA), 64'h0);

    // Next frame; BB lands exactly on the threshold cycle and must be kept
    applyStimulus(0, 8'hAA);
    idleCycles(15);
    applyStimulus(0, 8'hBB);
    checkOutput("threshold_no_timeout", 64'(timeoutErrA), 64'h0);
    applyStimulus(0, 8'hCC);
    applyStimulus(0, 8'hDD);
    applyStimulus(0, 8'h01);
    checkOutput("frame2_valid", 64'(frameValidA), 64'h1);
    checkOutput("frame2_operands", 64'(operandsA), 64'hDDCC_BBAA);
    checkOutput("frame2_cmd", 64'(cmdA), 64'h01);

    // Byte arriving while a frame is held is dropped
    applyStimulus(0, 8'h99);
    checkOutput("overrun_pulse", 64'(overrunErrA), 64'h1);
    checkOutput("overrun_still_valid", 64'(frameValidA), 64'h1);
    idleCycles(1);
    checkOutput("overrun_single_pulse", 64'(overrunErrA), 64'h0);
    frameReadyA = 1'b1;
    idleCycles(1);
    frameReadyA = 1'b0;
    checkOutput("overrun_operands_kept", 64'(operandsA), 64'hDDCC_BBAA);
    checkOutput("overrun_cmd_kept", 64'(cmdA), 64'h01);

    // Reset in the middle of a frame
    applyStimulus(0, 8'h11);
    applyStimulus(0, 8'h22);
    applyStimulus(0, 8'h33);
    reset = 1'b0;
    #2;
    checkOutput("midrst_operands", 64'(operandsA), 64'h0);
    checkOutput("midrst_cmd", 64'(cmdA), 64'h0);
    checkOutput("midrst_data_out", 64'(dataOutA), 64'h0);
    checkOutput("midrst_state", 64'(stateDbgA), 64'h0);
    checkOutput("midrst_valid", 64'(frameValidA), 64'h0);
    idleCycles(1);
    reset = 1'b1;
    idleCycles(1);
    checkOutput("midrst_no_timeout", 64'(timeoutErrA), 64'h0);
    applyStimulus(0, 8'h01);
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h02);
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h05);
    checkOutput("frame3_valid", 64'(frameValidA), 64'h1);
    checkOutput("frame3_operands", 64'(operandsA), 64'h0002_0001);
    checkOutput("frame3_cmd", 64'(cmdA), 64'h05);

    // Three single-byte operands
    applyStimulus(1, 8'h0A);
    applyStimulus(1, 8'h0B);
    applyStimulus(1, 8'h0C);
    checkOutput("b_cmd_state", 64'(stateDbgB), 64'h1);
    applyStimulus(1, 8'h07);
    checkOutput("b_valid", 64'(frameValidB), 64'h1);
    checkOutput("b_operands", 64'(operandsB), 64'h0C0B0A);
    dataSelB = 2'd3; #1;
    checkOutput("b_sel_cmd", 64'(dataOutB), 64'h07);
    dataSelB = 2'd1; #1;
    checkOutput("b_sel_op1", 64'(dataOutB), 64'h0B);

    // Smallest frame: one operand byte plus command
    applyStimulus(2, 8'h5A);
    checkOutput("c_cmd_state", 64'(stateDbgC), 64'h1);
    applyStimulus(2, 8'h3C);
    checkOutput("c_valid", 64'(frameValidC), 64'h1);
    checkOutput("c_operands", 64'(operandsC), 64'h5A);
    dataSelC = 1'b1; #1;
    checkOutput("c_sel_cmd", 64'(dataOutC), 64'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
